// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: stall/flush controller state and stage control bundle.
package rv32i_types;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned PERF_CNT_W = 32;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } pipe_ctrl_state_t;

  typedef struct packed {
    logic pc_load;
    logic if_id_load;
    logic id_ex_load;
    logic ex_mem_load;
    logic mem_wb_load;
    logic if_id_flush;
    logic id_ex_flush;
  } pipe_ctrl_t;

  // Canonical control words, MSB = pc_load ... LSB = id_ex_flush.
  localparam pipe_ctrl_t CTRL_FREEZE = pipe_ctrl_t'(7'b00000_00);
  localparam pipe_ctrl_t CTRL_NORMAL = pipe_ctrl_t'(7'b11111_00);
  localparam pipe_ctrl_t CTRL_BRANCH = pipe_ctrl_t'(7'b11111_11);
  localparam pipe_ctrl_t CTRL_BUBBLE = pipe_ctrl_t'(7'b00111_01);

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX feeding a source the ID instruction reads.
module hazard_detect
  import rv32i_types::*;
(
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  output logic                  load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
  // x0 is never a real producer, so it can never create a hazard.
  assign load_use = ex_mem_read && (ex_rd != REG_ADDR_W'(0)) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 5-stage RV32I pipeline.
// Performance counters are built only when PIPELINE_CTRL_PERF_EN is defined.
module pipeline_ctrl
  import rv32i_types::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  imem_req,
  input  logic                  imem_resp,
  input  logic                  dmem_req,
  input  logic                  dmem_resp,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  br_taken,
  output logic                  pc_load,
  output logic                  if_id_load,
  output logic                  id_ex_load,
  output logic                  ex_mem_load,
  output logic                  mem_wb_load,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  imem_hold,
  output logic                  dmem_hold,
  output logic [PERF_CNT_W-1:0] stall_cycles,
  output logic [PERF_CNT_W-1:0] bubble_count,
  output logic [PERF_CNT_W-1:0] flush_count
);

  pipe_ctrl_state_t state_q;
  pipe_ctrl_state_t state_d;
  pipe_ctrl_t       ctrl;
  logic             i_ok;
  logic             d_ok;
  logic             advance;
  logic             load_use;

  hazard_detect u_hazard_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .load_use    (load_use)
  );

  // A latched response on one port counts as satisfied until the other arrives.
  always_comb begin
    i_ok    = !imem_req || imem_resp || (state_q == WAIT_D);
    d_ok    = !dmem_req || dmem_resp || (state_q == WAIT_I);
    advance = i_ok && d_ok;
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (imem_resp && dmem_req && !dmem_resp) begin
          state_d = WAIT_D;
        end else if (dmem_resp && imem_req && !imem_resp) begin
          state_d = WAIT_I;
        end
      end
      WAIT_I, WAIT_D: begin
        if (advance) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Priority: reset, memory stall, taken branch, load-use bubble, normal flow.
  always_comb begin
    ctrl = CTRL_FREEZE;
    if (rst || !advance) begin
      ctrl = CTRL_FREEZE;
    end else if (br_taken) begin
      ctrl = CTRL_BRANCH;
    end else if (load_use) begin
      ctrl = CTRL_BUBBLE;
    end else begin
      ctrl = CTRL_NORMAL;
    end
  end

  assign pc_load     = ctrl.pc_load;
  assign if_id_load  = ctrl.if_id_load;
  assign id_ex_load  = ctrl.id_ex_load;
  assign ex_mem_load = ctrl.ex_mem_load;
  assign mem_wb_load = ctrl.mem_wb_load;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_flush = ctrl.id_ex_flush;
  assign imem_hold   = !rst && (state_q == WAIT_D);
  assign dmem_hold   = !rst && (state_q == WAIT_I);

`ifdef PIPELINE_CTRL_PERF_EN
  logic [PERF_CNT_W-1:0] stall_q;
  logic [PERF_CNT_W-1:0] bubble_q;
  logic [PERF_CNT_W-1:0] flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      if (!advance) begin
        stall_q <= stall_q + PERF_CNT_W'(1);
      end
      if (advance && !br_taken && load_use) begin
        bubble_q <= bubble_q + PERF_CNT_W'(1);
      end
      if (advance && br_taken) begin
        flush_q <= flush_q + PERF_CNT_W'(1);
      end
    end
  end

  assign stall_cycles = stall_q;
  assign bubble_count = bubble_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign bubble_count = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed vectors push expectations, a negedge monitor checks.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_resp, dmem_req, dmem_resp;
  logic        ex_mem_read, id_uses_rs1, id_uses_rs2, br_taken;
  logic [4:0]  ex_rd, id_rs1, id_rs2;
  logic        pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
  logic        if_id_flush, id_ex_flush, imem_hold, dmem_hold;
  logic [31:0] stall_cycles, bubble_count, flush_count;

  localparam logic [6:0] FRZ = 7'b00000_00;
  localparam logic [6:0] NRM = 7'b11111_00;
  localparam logic [6:0] BRF = 7'b11111_11;
  localparam logic [6:0] BUB = 7'b00111_01;

  typedef struct {
    int          idx;
    logic [6:0]  ctrl;
    logic [1:0]  hold;
    logic [31:0] s;
    logic [31:0] b;
    logic [31:0] f;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   vec_idx  = 0;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_resp    (imem_resp),
    .dmem_req     (dmem_req),
    .dmem_resp    (dmem_resp),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .br_taken     (br_taken),
    .pc_load      (pc_load),
    .if_id_load   (if_id_load),
    .id_ex_load   (id_ex_load),
    .ex_mem_load  (ex_mem_load),
    .mem_wb_load  (mem_wb_load),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .imem_hold    (imem_hold),
    .dmem_hold    (dmem_hold),
    .stall_cycles (stall_cycles),
    .bubble_count (bubble_count),
    .flush_count  (flush_count)
  );

  function automatic logic [31:0] perf(input int v);
`ifdef PIPELINE_CTRL_PERF_EN
    return 32'(v);
`else
    return 32'(v) & 32'd0;
`endif
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, got, want);
  endtask

  // Apply one cycle of inputs and queue the outputs expected in that cycle.
  task automatic vec(input logic r, input logic ir, input logic irs, input logic dr, input logic drs,
                     input logic emr, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic br,
                     input logic [6:0] ctrl, input logic ih, input logic dh,
                     input int s, input int b, input int f);
    exp_t e;
    rst = r; imem_req = ir; imem_resp = irs; dmem_req = dr; dmem_resp = drs;
    ex_mem_read = emr; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_uses_rs1 = u1; id_uses_rs2 = u2; br_taken = br;
    e.idx = vec_idx; e.ctrl = ctrl; e.hold = {ih, dh};
    e.s = perf(s); e.b = perf(b); e.f = perf(f);
    exp_q.push_back(e);
    vec_idx++;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("ctrl", e.idx, 32'({pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                               if_id_flush, id_ex_flush}), 32'(e.ctrl));
      check("hold", e.idx, 32'({imem_hold, dmem_hold}), 32'(e.hold));
      check("stall_cycles", e.idx, stall_cycles, e.s);
      check("bubble_count", e.idx, bubble_count, e.b);
      check("flush_count", e.idx, flush_count, e.f);
    end
  end

  initial begin
    rst = 1'b1; imem_req = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
    ex_mem_read = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; br_taken = 0;
    repeat (2) @(posedge clk);
    #1;
    //   r ir irs dr drs emr rd  rs1 rs2 u1 u2 br  ctrl ih dh  s  b  f
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FRZ, 0, 0, 0, 0, 0);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 0, 0, 0, 0);
    // load-use on rs1, then the load moves to MEM
    vec(0, 0, 0, 0, 0, 1, 5, 5, 1, 1, 1, 0, BUB, 0, 0, 0, 0, 0);
    vec(0, 0, 0, 1, 1, 0, 0, 6, 0, 1, 0, 0, NRM, 0, 0, 0, 1, 0);
    // x0 destination, unused rs2 match, used rs2 match
    vec(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, NRM, 0, 0, 0, 1, 0);
    vec(0, 0, 0, 0, 0, 1, 7, 3, 7, 1, 0, 0, NRM, 0, 0, 0, 1, 0);
    vec(0, 0, 0, 0, 0, 1, 7, 3, 7, 1, 1, 0, BUB, 0, 0, 0, 1, 0);
    // split response, imem first
    vec(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, FRZ, 0, 0, 0, 2, 0);
    vec(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, FRZ, 0, 0, 1, 2, 0);
    vec(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, FRZ, 1, 0, 2, 2, 0);
    vec(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, FRZ, 1, 0, 3, 2, 0);
    vec(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, NRM, 1, 0, 4, 2, 0);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 0, 4, 2, 0);
    // branch held across a data stall
    vec(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, FRZ, 0, 0, 4, 2, 0);
    vec(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, FRZ, 0, 0, 5, 2, 0);
    vec(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, FRZ, 0, 0, 6, 2, 0);
    vec(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, BRF, 0, 0, 7, 2, 0);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 0, 7, 2, 1);
    // branch wins over load-use
    vec(0, 0, 0, 0, 0, 1, 5, 5, 0, 1, 0, 1, BRF, 0, 0, 7, 2, 1);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 0, 7, 2, 2);
    // dmem first into WAIT_I, repeated dmem_resp ignored, then reset
    vec(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, FRZ, 0, 0, 7, 2, 2);
    vec(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, FRZ, 0, 1, 8, 2, 2);
    vec(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, FRZ, 0, 0, 9, 2, 2);
    vec(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, FRZ, 0, 0, 0, 0, 0);
    // simultaneous responses advance and stay in RUN
    vec(0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 0, 1, 0, 0);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 0, 1, 0, 0);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
